// File: rtl/pipe_ctrl.sv
// Pipeline hazard / memory-wait controller: freeze on outstanding data access, redirect flush,
// load-use bubble, and data-memory timeout abort. Optional PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_to_reg,
  input  logic        ex_redirect,
  input  logic        mem_access,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        mem_err,
  output logic        state_dbg
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

  state_t     state, state_next;
  logic [7:0] wcnt, wcnt_next;
  logic       abort_next;
  logic       freeze, redirect, load_use, hazard;

  // mem_err doubles as the abort-cycle marker: the aborted access must not re-freeze.
  always_comb begin
    hazard = ex_mem_to_reg && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    freeze   = mem_access && !dmem_ack && !mem_err;
    redirect = !freeze && ex_redirect;
    load_use = !freeze && !ex_redirect && hazard;
  end

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    abort_next = 1'b0;
    case (state)
      S_RUN: begin
        if (freeze) begin
          state_next = S_WAIT;
          wcnt_next  = 8'd1;
        end
      end
      S_WAIT: begin
        if (!freeze) begin
          state_next = S_RUN;
          wcnt_next  = 8'd0;
        end else if (wcnt == TIMEOUT_W) begin
          state_next = S_RUN;
          wcnt_next  = 8'd0;
          abort_next = 1'b1;
        end else begin
          wcnt_next = wcnt + 8'd1;
        end
      end
      default: begin
        state_next = S_RUN;
        wcnt_next  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RUN;
      wcnt    <= 8'd0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_next;
      wcnt    <= wcnt_next;
      mem_err <= abort_next;
    end
  end

  always_comb begin
    dmem_req     = mem_access && !mem_err;
    pc_stall     = freeze || load_use;
    if_id_stall  = freeze || load_use;
    id_ex_stall  = freeze;
    ex_mem_stall = freeze;
    if_id_flush  = redirect;
    id_ex_flush  = redirect || load_use;
    ex_mem_flush = mem_err;
    mem_wb_flush = freeze;
    state_dbg    = (state == S_WAIT);
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (pc_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (if_id_flush || id_ex_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal checks plus randomized traffic against a cycle-level model.
// Build with or without PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_to_reg = 0, ex_redirect = 0;
  logic mem_access = 0, dmem_ack = 0;
  logic dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err, state_dbg;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipe_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_to_reg(ex_mem_to_reg), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .mem_err(mem_err), .state_dbg(state_dbg)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_to_reg = 0; ex_redirect = 0;
    mem_access = 0; dmem_ack = 0;
  endtask

  // Model: m_n = consecutive frozen cycles of the current access, m_abort = this cycle is an abort.
  int          m_n = 0;
  bit          m_abort = 0;
  logic [31:0] m_stall = 0, m_flush = 0;

  always @(negedge clk) begin : model
    logic fz, rd, lu, hz, to;
    logic [10:0] e, a;
    if (rst) begin
      m_n = 0; m_abort = 0; m_stall = 0; m_flush = 0;
    end
    hz = ex_mem_to_reg && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    fz = !m_abort && mem_access && !dmem_ack;
    rd = !fz && ex_redirect;
    lu = !fz && !ex_redirect && hz;
    e = {mem_access && !m_abort, fz || lu, fz || lu, fz, fz, rd, rd || lu,
         m_abort, fz, m_abort, (m_n > 0)};
    a = {dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
         id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err, state_dbg};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL model_outputs: got %b expected %b at %0t", a, e, $time);
    end
`ifdef PIPE_CTRL_PERF_EN
    chk("model_perf_stall", perf_stall_cnt, m_stall);
    chk("model_perf_flush", perf_flush_cnt, m_flush);
`endif
    if (!rst) begin
      to = fz && (m_n == T);
      m_abort = to;
      m_n = fz ? (to ? 0 : m_n + 1) : 0;
      m_stall += 32'(fz || lu);
      m_flush += 32'(rd || lu);
    end
  end

  initial begin
    int ack_pct;
    idle();
    // Reset state
    @(negedge clk);
    chk("rst_pc_stall", pc_stall, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_state", state_dbg, 0);
    go(); rst = 0;

    // Load-use bubble, then the x0 exemption
    go(); ex_mem_to_reg = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    @(negedge clk);
    chk("lu_pc_stall", pc_stall, 1);
    chk("lu_if_id_stall", if_id_stall, 1);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    chk("lu_id_ex_stall", id_ex_stall, 0);
    go(); ex_rd = 0; id_rs1 = 0;
    @(negedge clk);
    chk("lu_x0_pc_stall", pc_stall, 0);

    // Redirect beats load-use
    go(); ex_rd = 5; id_rs1 = 5; ex_redirect = 1;
    @(negedge clk);
    chk("rd_if_id_flush", if_id_flush, 1);
    chk("rd_id_ex_flush", id_ex_flush, 1);
    chk("rd_pc_stall", pc_stall, 0);
    go(); idle();

    // Ack on 4th cycle: three frozen cycles
    for (int i = 0; i < 3; i++) begin
      go(); mem_access = 1;
      @(negedge clk);
      chk("wait_mem_wb_flush", mem_wb_flush, 1);
      chk("wait_state", state_dbg, (i > 0) ? 1 : 0);
    end
    go(); dmem_ack = 1;
    @(negedge clk);
    chk("ack_pc_stall", pc_stall, 0);
    chk("ack_mem_wb_flush", mem_wb_flush, 0);
    chk("ack_dmem_req", dmem_req, 1);
    go(); idle();
    @(negedge clk);
    chk("ack_mem_err", mem_err, 0);
    chk("ack_state", state_dbg, 0);

    // Timeout: T+1 frozen cycles, then one abort cycle
    for (int i = 0; i < T + 1; i++) begin
      go(); mem_access = 1;
      @(negedge clk);
      chk("to_frozen", pc_stall, 1);
    end
    go();
    @(negedge clk);
    chk("to_mem_err", mem_err, 1);
    chk("to_ex_mem_flush", ex_mem_flush, 1);
    chk("to_pc_stall", pc_stall, 0);
    chk("to_dmem_req", dmem_req, 0);
    chk("to_state", state_dbg, 0);
    go(); mem_access = 0;
    @(negedge clk);
    chk("to_err_once", mem_err, 0);

    // Ack in the timeout cycle wins
    for (int i = 0; i < T; i++) begin
      go(); mem_access = 1;
      @(negedge clk);
    end
    go(); dmem_ack = 1;
    @(negedge clk);
    chk("to_ack_pc_stall", pc_stall, 0);
    go(); idle();
    @(negedge clk);
    chk("to_ack_mem_err", mem_err, 0);

    // Redirect deferred across a freeze
    for (int i = 0; i < 3; i++) begin
      go(); mem_access = 1; ex_redirect = 1;
      @(negedge clk);
      chk("defer_if_id_flush", if_id_flush, 0);
    end
    go(); dmem_ack = 1;
    @(negedge clk);
    chk("defer_if_id_flush_ack", if_id_flush, 1);
    chk("defer_id_ex_flush_ack", id_ex_flush, 1);
    go(); idle();

    // Reset pulse mid-WAIT
    go(); mem_access = 1;
    go();
    @(negedge clk);
    chk("mid_wait_state", state_dbg, 1);
    go(); rst = 1;
    @(negedge clk);
    chk("mid_rst_state", state_dbg, 0);
    chk("mid_rst_mem_err", mem_err, 0);
`ifdef PIPE_CTRL_PERF_EN
    chk("mid_rst_perf_stall", perf_stall_cnt, 0);
    chk("mid_rst_perf_flush", perf_flush_cnt, 0);
`endif
    go(); rst = 0; idle();

    // Randomized traffic, checked by the model every cycle
    ack_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      go();
      if (c % 500 == 0) ack_pct = $urandom_range(0, 60);
      rst = ($urandom_range(0, 299) == 0);
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      ex_rd = 5'($urandom_range(0, 7));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_mem_to_reg = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 5) == 0);
      if (mem_access && !dmem_ack) mem_access = ($urandom_range(0, 9) != 0);
      else mem_access = ($urandom_range(0, 2) == 0);
      dmem_ack = mem_access && ($urandom_range(0, 99) < ack_pct);
    end
    go(); idle(); rst = 0;
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
